// File: rtl/seg_display_capture.sv
// seg_display_capture: recovers hex nibbles from a multiplexed, active-low 7-segment bus.
// Filters digit-switch glitches, flags blank/undecodable digits and reports whole frames.
module seg_display_capture #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [0:6]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] valor,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    timeout
);
    localparam int unsigned BUS_W  = 7 + NUM_DIGITS;
    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_TRACK = 2'd0,
        S_HOLD  = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    // Pattern bit 6 is segment a; result is {invalid, blank, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        r = 6'b10_0000;
        case (p)
            7'b0000001: r = 6'h00;
            7'b1001111: r = 6'h01;
            7'b0010010: r = 6'h02;
            7'b0000110: r = 6'h03;
            7'b1001100: r = 6'h04;
            7'b0100100: r = 6'h05;
            7'b0100000: r = 6'h06;
            7'b0001111: r = 6'h07;
            7'b0000000: r = 6'h08;
            7'b0000100: r = 6'h09;
            7'b0001000: r = 6'h0A;
            7'b1100000: r = 6'h0B;
            7'b0110001: r = 6'h0C;
            7'b1000010: r = 6'h0D;
            7'b0110000: r = 6'h0E;
            7'b0111000: r = 6'h0F;
            7'b1111111: r = 6'b01_0000;
            default:    r = 6'b10_0000;
        endcase
        return r;
    endfunction

    state_t                    r_state;
    logic [BUS_W-1:0]          r_s1;
    logic [BUS_W-1:0]          r_s2;
    logic [BUS_W-1:0]          r_prev;
    logic [STAB_W-1:0]         r_stab;
    logic [IDLE_W-1:0]         r_idle;
    logic [NUM_DIGITS-1:0]     r_seen;
    logic [4*NUM_DIGITS-1:0]   r_nib_sh;
    logic [NUM_DIGITS-1:0]     r_blank_sh;
    logic [NUM_DIGITS-1:0]     r_err_sh;

    logic                      w_same;
    logic [STAB_W-1:0]         w_stab_next;
    logic [6:0]                w_seg;
    logic [NUM_DIGITS-1:0]     w_sel;
    logic                      w_onehot;
    logic                      w_capture;
    logic [NUM_DIGITS-1:0]     w_seen_cap;
    logic [5:0]                w_dec;
    logic [IDLE_W-1:0]         w_idle_inc;

    // Stability tracking and capture qualification on the synchronised bus
    always_comb begin
        w_same      = (r_s2 == r_prev);
        w_stab_next = '0;
        if (w_same) begin
            w_stab_next = (r_stab == STAB_MAX) ? r_stab : r_stab + STAB_W'(1);
        end
        w_seg      = r_s2[BUS_W-1 -: 7];
        w_sel      = ~r_s2[NUM_DIGITS-1:0];
        w_onehot   = (w_sel != '0) && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
        w_capture  = (r_state == S_TRACK) && (w_stab_next == STAB_MAX) && w_onehot;
        w_seen_cap = r_seen | w_sel;
        w_dec      = decode(w_seg);
        w_idle_inc = r_idle + IDLE_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_TRACK;
            r_s1        <= '0;
            r_s2        <= '0;
            r_prev      <= '0;
            r_stab      <= '0;
            r_idle      <= '0;
            r_seen      <= '0;
            r_nib_sh    <= '0;
            r_blank_sh  <= '0;
            r_err_sh    <= '0;
            valor       <= '0;
            blank       <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_s1        <= {seg, an};
            r_s2        <= r_s1;
            r_prev      <= r_s2;
            r_stab      <= w_stab_next;
            frame_valid <= 1'b0;

            case (r_state)
                S_TRACK: begin
                    if (w_capture) begin
                        r_state <= (&w_seen_cap) ? S_FRAME : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!w_same) begin
                        r_state <= S_TRACK;
                    end
                end
                S_FRAME: begin
                    valor       <= r_nib_sh;
                    blank       <= r_blank_sh;
                    digit_err   <= r_err_sh;
                    frame_valid <= 1'b1;
                    timeout     <= 1'b0;
                    r_seen      <= '0;
                    r_state     <= w_same ? S_HOLD : S_TRACK;
                end
                default: r_state <= S_TRACK;
            endcase

            // Shadow update on capture; otherwise the idle counter runs toward timeout
            if (w_capture) begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (w_sel[i]) begin
                        r_nib_sh[4*i +: 4] <= (w_dec[5:4] == 2'b00) ? w_dec[3:0] : 4'h0;
                        r_blank_sh[i]      <= w_dec[4];
                        r_err_sh[i]        <= w_dec[5];
                    end
                end
                r_seen <= (&w_seen_cap) ? r_seen : w_seen_cap;
                r_idle <= '0;
            end else if (r_idle != IDLE_MAX) begin
                r_idle <= w_idle_inc;
                if (w_idle_inc == IDLE_MAX) begin
                    timeout <= 1'b1;
                    r_seen  <= '0;
                end
            end
        end
    end

endmodule
